// File: rtl/md_issue_ctrl.sv
// Issue/interlock controller between the E-stage register and the multiply/divide unit.
// Launches MD ops as one-cycle pulses, strobes HI/LO writes and stalls dependent MD instructions.
module md_issue_ctrl #(
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [5:0]       e_opcode,
  input  logic [5:0]       e_funct,
  input  logic [31:0]      e_rs_val,
  input  logic [31:0]      e_rt_val,
  input  logic             flush,
  input  logic             md_busy_in,
  output logic [3:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  output logic             md_hi_we,
  output logic             md_lo_we,
  output logic [31:0]      md_wdata,
  output logic             md_out_sel,
  output logic             md_stall,
  output logic             div0_flag,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       md_state_dbg
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TO_V = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc;
  logic [3:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              div0_q, div0_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic dec_ok;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo, is_launch, is_div_op, is_md;
  logic blocked, launch_ok, div0_hit, capture, err_set;

  // Decode is only meaningful for SPECIAL-opcode instructions that are not bubbles.
  always_comb begin
    dec_ok    = e_valid & (e_opcode == 6'd0);
    is_mfhi   = dec_ok & (e_funct == 6'h10);
    is_mthi   = dec_ok & (e_funct == 6'h11);
    is_mflo   = dec_ok & (e_funct == 6'h12);
    is_mtlo   = dec_ok & (e_funct == 6'h13);
    is_launch = dec_ok & (e_funct[5:2] == 4'b0110);
    is_div_op = is_launch & e_funct[1];
    is_md     = is_mfhi | is_mthi | is_mflo | is_mtlo | is_launch;
    blocked   = (state_q != S_IDLE) | md_busy_in;
    launch_ok = (state_q == S_IDLE) & is_launch & ~blocked & ~flush;
    div0_hit  = launch_ok & is_div_op & (e_rt_val == 32'd0);
    capture   = launch_ok & ~div0_hit;
  end

  assign md_stall   = is_md & blocked & ~flush;
  assign md_hi_we   = is_mthi & ~blocked & ~flush & ~reset;
  assign md_lo_we   = is_mtlo & ~blocked & ~flush & ~reset;
  assign md_wdata   = e_rs_val;
  assign md_out_sel = (is_mfhi | is_mflo) & e_funct[1];

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        wd_d = wd_inc;
        if (!md_busy_in) begin
          state_d = S_IDLE;
        end else if (wd_inc == TO_V) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // op_q is loaded at capture and cleared on the next edge, so it is non-zero only in ISSUE.
  always_comb begin
    op_d   = capture ? {1'b0, e_funct[1], ~e_funct[1], e_funct[0]} : 4'd0;
    a_d    = capture ? e_rs_val : a_q;
    b_d    = capture ? e_rt_val : b_q;
    div0_d = div0_q | div0_hit;
    err_d  = err_q | err_set;
    cnt_d  = cnt_q;
    if (md_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div0_q  <= div0_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_op        = op_q;
  assign md_a         = a_q;
  assign md_b         = b_q;
  assign div0_flag    = div0_q;
  assign md_err       = err_q;
  assign stall_cnt    = cnt_q;
  assign md_state_dbg = state_q;

endmodule
